aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_wait_timer.sv | 32 +++
 rtl/aes_round_ctrl.sv | 127 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller slice.
package aes_pkg;

  localparam int unsigned AES_DATA_LEN = 128;
  localparam int unsigned AES_NR       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_wait_timer.sv
// Per-round watchdog: cleared by load, advanced by count_en. expired flags
// that the cycle being counted is the TIMEOUT-th one without a result.
module aes_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Expiry depends only on the register so the controller can gate it
  // with its own count enable without forming a combinational loop.
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  // Counter register: load restarts the window, count_en advances it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count_en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a block, issues NR rounds to an external
// round datapath, guards each round with a watchdog, and hands the
// ciphertext downstream.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned DATA_LEN = AES_DATA_LEN,
  parameter int unsigned NR       = AES_NR,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [DATA_LEN-1:0] data_in,
  output logic                ready_out,
  output logic                round_valid_out,
  output logic [DATA_LEN-1:0] round_data_out,
  output logic [3:0]          round_idx,
  output logic                last_round,
  input  logic                round_valid_in,
  input  logic [DATA_LEN-1:0] round_data_in,
  output logic                valid_out,
  output logic [DATA_LEN-1:0] data_out,
  input  logic                out_ready,
  output logic                err,
  input  logic                err_clr
);

  aes_state_e          state_q, state_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic [3:0]          idx_q, idx_d;
  logic                err_q, err_set;
  logic                tmr_load, tmr_en, tmr_expired;
  logic                is_last;

  assign is_last = (idx_q == 4'(NR));

  aes_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .count_en (tmr_en),
    .expired  (tmr_expired)
  );

  // State, round state, round index and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // Next-state logic, watchdog control and error detection.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    // A result strobe is only meaningful while waiting for one.
    err_set  = round_valid_in && (state_q != ST_WAIT);
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          data_d   = data_in;
          idx_d    = 4'd1;
          tmr_load = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (round_valid_in) begin
          data_d = round_data_in;
          if (is_last) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_ISSUE;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            err_set = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ready_out is qualified by reset so every output reads 0 while held.
  assign ready_out       = (state_q == ST_IDLE) && reset;
  assign round_valid_out = (state_q == ST_ISSUE);
  assign round_data_out  = data_q;
  assign round_idx       = idx_q;
  assign last_round      = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && is_last;
  assign valid_out       = (state_q == ST_DONE);
  assign data_out        = data_q;
  assign err             = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with a reference AES round datapath.
module tb_aes_round_ctrl;

  localparam int unsigned NR = 10;

  logic         clk;
  logic         reset;
  logic         valid_in;
  logic [127:0] data_in;
  logic         ready_out;
  logic         round_valid_out;
  logic [127:0] round_data_out;
  logic [3:0]   round_idx;
  logic         last_round;
  logic         round_valid_in;
  logic [127:0] round_data_in;
  logic         valid_out;
  logic [127:0] data_out;
  logic         out_ready;
  logic         err;
  logic         err_clr;

  logic         dp_rvi, man_rvi;
  logic         dp_on;
  logic [3:0]   dp_drop;
  int unsigned  dp_lat;

  int unsigned  tests, failed;
  int unsigned  rvo_cnt, vout_cnt, acc_cnt, last_bad, rvo_dbl;
  logic         prev_rvo, prev_vout;

  logic [7:0]   sbox [256];
  logic [31:0]  w [44];

  assign round_valid_in = dp_rvi | man_rvi;

  aes_round_ctrl #(
    .DATA_LEN (128),
    .NR       (NR),
    .TIMEOUT  (15)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .ready_out       (ready_out),
    .round_valid_out (round_valid_out),
    .round_data_out  (round_data_out),
    .round_idx       (round_idx),
    .last_round      (last_round),
    .round_valid_in  (round_valid_in),
    .round_data_in   (round_data_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .out_ready       (out_ready),
    .err             (err),
    .err_clr         (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference AES round model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] st, input int r);
    logic [7:0]   s1 [16];
    logic [7:0]   s2 [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int j = 0; j < 16; j++) s1[j] = sbox[st[127-8*j -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) s2[rr+4*c] = s1[rr + 4*((c+rr)%4)];
    if (r != NR) begin
      for (int c = 0; c < 4; c++) begin
        a0 = s2[4*c]; a1 = s2[4*c+1]; a2 = s2[4*c+2]; a3 = s2[4*c+3];
        s2[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        s2[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        s2[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        s2[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s2[j];
    return o ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Round datapath: answers each issue strobe dp_lat cycles later.
  initial begin
    logic [127:0] res;
    dp_rvi = 1'b0;
    round_data_in = '0;
    forever begin
      @(posedge clk); #1;
      while (dp_on && round_valid_out && round_idx != dp_drop) begin
        res = aes_round(round_data_out, int'(round_idx));
        repeat (dp_lat) @(posedge clk);
        #1;
        dp_rvi = 1'b1;
        round_data_in = res;
        @(posedge clk); #1;
        dp_rvi = 1'b0;
      end
    end
  end

  // Protocol monitor sampled on the falling edge.
  initial begin
    rvo_cnt = 0; vout_cnt = 0; acc_cnt = 0; last_bad = 0; rvo_dbl = 0;
    prev_rvo = 1'b0; prev_vout = 1'b0;
    forever begin
      @(negedge clk);
      if (round_valid_out) rvo_cnt++;
      if (round_valid_out && prev_rvo) rvo_dbl++;
      if (valid_out && !prev_vout) vout_cnt++;
      if (valid_in && ready_out) acc_cnt++;
      if (last_round && round_idx != 4'(NR)) last_bad++;
      if (round_valid_out && round_idx == 4'(NR) && !last_round) last_bad++;
      prev_rvo  = round_valid_out;
      prev_vout = valid_out;
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Offer a block and return once it has been accepted (or the bound ran out).
  task automatic start_block(input logic [127:0] din, output bit ok);
    int unsigned n = 0;
    @(negedge clk);
    data_in  = din;
    valid_in = 1'b1;
    while (!ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = ready_out;
    if (ok) begin
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  // Run one block to valid_out; cyc counts the cycle after the accepting edge as 1.
  task automatic run_block(input logic [127:0] key, input logic [127:0] din,
                           input int unsigned lat, output logic [127:0] ct,
                           output int unsigned cyc, output bit ok);
    set_key(key);
    dp_lat = lat;
    cyc = 0;
    ct  = '0;
    start_block(din, ok);
    if (ok) begin
      cyc = 1;
      while (!valid_out && cyc < 400) begin
        @(posedge clk); #1;
        cyc++;
      end
      ok = valid_out;
      ct = data_out;
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] din;
    int unsigned  lat;
    logic [127:0] ct;
    int unsigned  cyc;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [127:0] ct;
    int unsigned  cyc, n, r0, lb0, vo0, a0;
    bit           ok;

    tests = 0; failed = 0;
    reset = 1'b0; valid_in = 1'b0; data_in = '0; out_ready = 1'b1;
    err_clr = 1'b0; man_rvi = 1'b0; dp_on = 1'b1; dp_drop = 4'd0; dp_lat = 1;

    // key, data after initial AddRoundKey, latency, ciphertext, valid_out cycle
    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00102030405060708090a0b0c0d0e0f0,
              1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 21};
    vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
              2, 128'h3925841d02dc09fbdc118597196a0b32, 31};
    vt[2] = '{128'h0, 128'h0, 3, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 41};
    vt[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00102030405060708090a0b0c0d0e0f0,
              4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 51};

    build_sbox();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl_outs", 128'({ready_out, round_valid_out, round_idx, last_round, valid_out, err}), '0);
    chk("reset_data_out", data_out, '0);
    chk("reset_round_data", round_data_out, '0);
    reset = 1'b1;
    #1;
    chk("ready_after_release", 128'(ready_out), 128'(1));

    // Table-driven blocks
    for (int i = 0; i < 4; i++) begin
      r0 = rvo_cnt; lb0 = last_bad;
      run_block(vt[i].key, vt[i].din, vt[i].lat, ct, cyc, ok);
      chk($sformatf("vec%0d_completed", i), 128'(ok), 128'(1));
      chk($sformatf("vec%0d_ciphertext", i), ct, vt[i].ct);
      chk($sformatf("vec%0d_latency", i), 128'(cyc), 128'(vt[i].cyc));
      chk($sformatf("vec%0d_issue_count", i), 128'(rvo_cnt - r0), 128'(NR));
      chk($sformatf("vec%0d_last_round", i), 128'(last_bad - lb0), '0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_back_to_idle", i), 128'({valid_out, ready_out, err, round_idx}), 128'(7'b0100000));
    end

    // Downstream stall in DONE
    out_ready = 1'b0;
    run_block(vt[0].key, vt[0].din, 1, ct, cyc, ok);
    chk("stall_ct", ct, vt[0].ct);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_handshake", k), 128'({valid_out, ready_out}), 128'(2'b10));
      chk($sformatf("stall%0d_data", k), data_out, vt[0].ct);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 128'({valid_out, ready_out}), 128'(2'b01));

    // Datapath withholds round 3 result
    vo0 = vout_cnt;
    dp_drop = 4'd3;
    set_key(vt[0].key);
    dp_lat = 1;
    start_block(vt[0].din, ok);
    n = 0;
    while (!(round_valid_out && round_idx == 4'd3) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_round3_issued", 128'(round_valid_out && round_idx == 4'd3), 128'(1));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!err && n < 40);
    chk("to_edges_to_err", 128'(n), 128'(16));
    chk("to_state", 128'({ready_out, round_idx, valid_out}), 128'(6'b100000));
    chk("to_no_valid_out", 128'(vout_cnt - vo0), '0);
    repeat (3) @(posedge clk);
    #1;
    chk("to_err_sticky", 128'(err), 128'(1));
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_cleared", 128'(err), '0);
    dp_drop = 4'd0;

    // err_clr together with a new error: set wins
    @(negedge clk); err_clr = 1'b1; man_rvi = 1'b1;
    @(negedge clk); err_clr = 1'b0; man_rvi = 1'b0;
    chk("set_wins", 128'(err), 128'(1));
    chk("idle_rvi_ignored", 128'({ready_out, round_valid_out, round_idx}), 128'(6'b100000));
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Reset pulsed during round 5
    dp_drop = 4'd5;
    set_key(vt[0].key);
    dp_lat = 2;
    start_block(vt[0].din, ok);
    n = 0;
    while (!(round_valid_out && round_idx == 4'd5) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_round5_issued", 128'(round_valid_out && round_idx == 4'd5), 128'(1));
    #2 reset = 1'b0;
    #1;
    chk("rst_ctrl_outs", 128'({ready_out, round_valid_out, round_idx, last_round, valid_out, err}), '0);
    chk("rst_data_out", data_out, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_ready_after_release", 128'(ready_out), 128'(1));
    @(negedge clk); man_rvi = 1'b1;
    @(negedge clk); man_rvi = 1'b0;
    chk("rst_late_rvi_err", 128'(err), 128'(1));
    chk("rst_late_rvi_ignored", 128'({ready_out, round_valid_out, round_idx}), 128'(6'b100000));
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    dp_drop = 4'd0;
    run_block(vt[0].key, vt[0].din, 1, ct, cyc, ok);
    chk("rst_next_block_ct", ct, vt[0].ct);
    chk("rst_next_block_err", 128'(err), '0);

    // Back-to-back blocks with upstream holding valid_in, random latency
    @(posedge clk); #1;
    a0 = acc_cnt; r0 = rvo_cnt;
    valid_in = 1'b1;
    data_in  = vt[0].din;
    for (int b = 0; b < 5; b++) begin
      n = 0;
      @(negedge clk);
      while (!ready_out && n < 100) begin
        @(negedge clk);
        n++;
      end
      set_key(vt[b % 3].key);
      dp_lat = $urandom_range(4, 1);
      @(posedge clk); #1;
      data_in = vt[(b + 1) % 3].din;
      if (b == 4) valid_in = 1'b0;
      n = 0;
      while (!valid_out && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("b2b%0d_ct", b), data_out, vt[b % 3].ct);
    end
    valid_in = 1'b0;
    chk("b2b_accepted", 128'(acc_cnt - a0), 128'(5));
    chk("b2b_issue_count", 128'(rvo_cnt - r0), 128'(5 * NR));

    repeat (3) @(posedge clk);
    chk("issue_single_cycle", 128'(rvo_dbl), '0);
    chk("last_round_overall", 128'(last_bad), '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
